// File: rtl/nos_dac_serializer_pkg.sv
// nos_dac_serializer_pkg: shared types and helpers for the NOS DAC serializer.
//   I2S_BITS        : PCM word width per channel (MSB-aligned)
//   LANE_BITS       : width of a per-channel shift lane
//   NOS_BITNUM      : DAC word-width selector (16/18/20/24 bits)
//   nos_bits()      : selector -> bit count
//   nos_ser_state_t : serializer FSM states
package nos_dac_serializer_pkg;

    localparam int unsigned I2S_BITS  = 32;
    localparam int unsigned LANE_BITS = 24;

    typedef enum logic [1:0] {
        NOS16 = 2'd0,
        NOS18 = 2'd1,
        NOS20 = 2'd2,
        NOS24 = 2'd3
    } NOS_BITNUM;

    typedef enum logic [2:0] {
        StIdle,
        StPreLo,
        StPreHi,
        StDatLo,
        StDatHi,
        StLeLo,
        StLeHi
    } nos_ser_state_t;

    function automatic logic [4:0] nos_bits(input NOS_BITNUM bitnum);
        logic [4:0] n;
        case (bitnum)
            NOS16:   n = 5'd16;
            NOS18:   n = 5'd18;
            NOS20:   n = 5'd20;
            default: n = 5'd24;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/nos_dac_serializer_lane.sv
// nos_dac_ser_lane: one channel's 24-bit load/shift register.
//   clk, reset : system clock, asynchronous active-high reset
//   load       : capture a new word (top load_bits bits, right-aligned)
//   shift      : shift the lane left by one bit
//   word       : 32-bit MSB-aligned PCM word
//   load_bits  : word width used for the capture
//   invert     : flip the sign bit at capture (two's complement -> offset binary)
//   cur_bits   : word width of the frame in flight, selects the output bit
//   msb        : current serial bit (lane bit cur_bits-1)
module nos_dac_ser_lane
    import nos_dac_serializer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                shift,
    input  logic [I2S_BITS-1:0] word,
    input  logic [4:0]          load_bits,
    input  logic                invert,
    input  logic [4:0]          cur_bits,
    output logic                msb
);

    logic [LANE_BITS-1:0] lane_q;
    logic [LANE_BITS-1:0] load_val;

    // Keep the top load_bits bits of the word, zero-extended into the lane.
    always_comb begin
        load_val = LANE_BITS'(word >> (6'd32 - {1'b0, load_bits}));
        if (invert) begin
            load_val[load_bits - 5'd1] = ~load_val[load_bits - 5'd1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q <= '0;
        end else if (load) begin
            lane_q <= load_val;
        end else if (shift) begin
            lane_q <= {lane_q[LANE_BITS-2:0], 1'b0};
        end
    end

    assign msb = lane_q[cur_bits - 5'd1];

endmodule

// File: rtl/nos_dac_serializer.sv
// nos_dac_serializer: N_CH-channel PCM -> simultaneous-mode NOS DAC serial streams.
// One-entry input buffer (valid/ready), programmable bit-clock divider, FSM producing
// preamble / data / latch-bit periods.
//   clk, reset   : system clock, asynchronous active-high reset
//   s_data       : N_CH x 32-bit MSB-aligned sample words (ch k at [32k+31:32k])
//   s_valid      : sample present
//   s_ready      : buffer can accept
//   nos_bitnum   : DAC word width, captured at frame load
//   bck_cont     : 1 = bck toggles during the preamble, captured at frame load
//   offset_bin   : (only with NOS_DAC_SER_OFFSET_BIN_EN) invert sign bit, captured at load
//   bck, le      : DAC bit clock and latch enable
//   data_out     : one serial data line per channel, MSB first
//   busy         : frame in progress
//   underrun     : one-cycle pulse after a frame ends with the buffer empty
// Optional feature macro: NOS_DAC_SER_OFFSET_BIN_EN.
module nos_dac_serializer
    import nos_dac_serializer_pkg::*;
#(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned FRAME_BCKS = 32,
    parameter int unsigned HALF_DIV   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH*I2S_BITS-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  NOS_BITNUM                nos_bitnum,
    input  logic                     bck_cont,
`ifdef NOS_DAC_SER_OFFSET_BIN_EN
    input  logic                     offset_bin,
`endif
    output logic                     bck,
    output logic                     le,
    output logic [N_CH-1:0]          data_out,
    output logic                     busy,
    output logic                     underrun
);

    localparam int unsigned PW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(HALF_DIV - 1);
    localparam logic [7:0] FRAME_LEN = 8'(FRAME_BCKS);

    nos_ser_state_t state_q, state_d;

    logic [PW-1:0]              phase_q, phase_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic [4:0]                 nbits_q;
    logic                       bck_cont_q;
    logic                       buf_full_q;
    logic [N_CH*I2S_BITS-1:0]   buf_data_q;
    logic                       rdy_en_q;
    logic                       underrun_q, underrun_d;
    logic                       load, shift, accept, ph_end, invert_load;
    logic [4:0]                 load_bits;
    logic [7:0]                 pre_len;
    logic [N_CH-1:0]            lane_msb;

`ifdef NOS_DAC_SER_OFFSET_BIN_EN
    assign invert_load = offset_bin;
`else
    assign invert_load = 1'b0;
`endif

    assign load_bits = nos_bits(nos_bitnum);
    assign pre_len   = FRAME_LEN - {3'b000, load_bits};
    assign ph_end    = (phase_q == PH_LAST);

    // rdy_en_q holds s_ready low until the first edge after reset release.
    assign s_ready = rdy_en_q & ~buf_full_q & ~reset;
    assign accept  = s_valid & s_ready;

    // Input buffer. Accept needs an empty buffer and load needs a full one, so the
    // two never coincide and a load never passes a same-edge word through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_full_q <= 1'b0;
            buf_data_q <= '0;
            rdy_en_q   <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (accept) begin
                buf_full_q <= 1'b1;
                buf_data_q <= s_data;
            end else if (load) begin
                buf_full_q <= 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters and per-frame configuration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q    <= '0;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
            nbits_q    <= 5'd16;
            bck_cont_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
            if (load) begin
                nbits_q    <= load_bits;
                bck_cont_q <= bck_cont;
            end
        end
    end

    always_comb begin
        phase_d = phase_q + PW'(1);
        if (state_q == StIdle || load || ph_end) begin
            phase_d = '0;
        end
    end

    // Next-state logic. The period counter exits a section when a high-phase end
    // would take it from 1 to 0.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load       = 1'b0;
        shift      = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (buf_full_q) load = 1'b1;
            end
            StPreLo: begin
                if (ph_end) state_d = StPreHi;
            end
            StPreHi: begin
                if (ph_end) begin
                    if (cnt_q == 8'd1) begin
                        state_d = StDatLo;
                        cnt_d   = {3'b000, nbits_q} - 8'd1;
                    end else begin
                        state_d = StPreLo;
                        cnt_d   = cnt_q - 8'd1;
                    end
                end
            end
            StDatLo: begin
                if (ph_end) state_d = StDatHi;
            end
            StDatHi: begin
                if (ph_end) begin
                    shift = 1'b1;
                    if (cnt_q == 8'd1) begin
                        state_d = StLeLo;
                    end else begin
                        state_d = StDatLo;
                        cnt_d   = cnt_q - 8'd1;
                    end
                end
            end
            StLeLo: begin
                if (ph_end) state_d = StLeHi;
            end
            StLeHi: begin
                if (ph_end) begin
                    if (buf_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d    = StIdle;
                        underrun_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            if (pre_len != 8'd0) begin
                state_d = StPreLo;
                cnt_d   = pre_len;
            end else begin
                state_d = StDatLo;
                cnt_d   = {3'b000, load_bits} - 8'd1;
            end
        end
    end

    // Outputs decode from registered state only, so reset clears them at once.
    always_comb begin
        bck      = 1'b0;
        le       = 1'b0;
        data_out = '0;
        busy     = 1'b1;
        underrun = underrun_q;
        case (state_q)
            StPreLo: ;
            StPreHi: bck = bck_cont_q;
            StDatLo: data_out = lane_msb;
            StDatHi: begin
                bck      = 1'b1;
                data_out = lane_msb;
            end
            StLeLo: begin
                le       = 1'b1;
                data_out = lane_msb;
            end
            StLeHi: begin
                bck      = 1'b1;
                le       = 1'b1;
                data_out = lane_msb;
            end
            default: busy = 1'b0;
        endcase
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        nos_dac_ser_lane u_lane (
            .clk       (clk),
            .reset     (reset),
            .load      (load),
            .shift     (shift),
            .word      (buf_data_q[k*I2S_BITS +: I2S_BITS]),
            .load_bits (load_bits),
            .invert    (invert_load),
            .cur_bits  (nbits_q),
            .msb       (lane_msb[k])
        );
    end

endmodule

// File: tb/tb_nos_dac_serializer.sv
// Bench for nos_dac_serializer: two instances (HALF_DIV 1 and 3) share stimulus; each is
// compared every cycle against a frame-position model, plus directed waveform checks.
module tb_nos_dac_serializer;
    import nos_dac_serializer_pkg::*;

    localparam int FB = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] s_data = '0;
    logic        s_valid = 1'b0;
    NOS_BITNUM   nos_bitnum = NOS16;
    logic        bck_cont = 1'b1;
`ifdef NOS_DAC_SER_OFFSET_BIN_EN
    logic        offset_bin = 1'b0;
`endif
    logic [1:0]  s_ready_v, bck_v, le_v, busy_v, und_v;
    logic [1:0]  dout0, dout1;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    nos_dac_serializer #(.N_CH(2), .FRAME_BCKS(FB), .HALF_DIV(1)) dut0 (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_v[0]),
        .nos_bitnum(nos_bitnum), .bck_cont(bck_cont),
`ifdef NOS_DAC_SER_OFFSET_BIN_EN
        .offset_bin(offset_bin),
`endif
        .bck(bck_v[0]), .le(le_v[0]), .data_out(dout0), .busy(busy_v[0]), .underrun(und_v[0])
    );

    nos_dac_serializer #(.N_CH(2), .FRAME_BCKS(FB), .HALF_DIV(3)) dut1 (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_v[1]),
        .nos_bitnum(nos_bitnum), .bck_cont(bck_cont),
`ifdef NOS_DAC_SER_OFFSET_BIN_EN
        .offset_bin(offset_bin),
`endif
        .bck(bck_v[1]), .le(le_v[1]), .data_out(dout1), .busy(busy_v[1]), .underrun(und_v[1])
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_pos [2];   // cycle index inside the current frame, -1 when idle
    int          m_n   [2];
    bit          m_full[2], m_rdy[2], m_under[2], m_cont[2], m_inv[2];
    logic [63:0] m_word[2], m_fw[2];

    function automatic int hd_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int width_of(input NOS_BITNUM b);
        case (b)
            NOS16: return 16;
            NOS18: return 18;
            NOS20: return 20;
            default: return 24;
        endcase
    endfunction

    function automatic bit cur_offset();
`ifdef NOS_DAC_SER_OFFSET_BIN_EN
        return offset_bin;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pos[i] = -1; m_full[i] = 0; m_rdy[i] = 0; m_under[i] = 0;
            m_n[i] = 16; m_cont[i] = 0; m_inv[i] = 0; m_word[i] = '0; m_fw[i] = '0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int len;
            bit acc, ending;
            len    = 2 * FB * hd_of(i);
            acc    = s_valid && m_rdy[i] && !m_full[i];
            ending = (m_pos[i] == len - 1);
            m_under[i] = ending && !m_full[i];
            if ((m_pos[i] < 0 || ending) && m_full[i]) begin
                m_pos[i]  = 0;
                m_n[i]    = width_of(nos_bitnum);
                m_cont[i] = bck_cont;
                m_inv[i]  = cur_offset();
                m_fw[i]   = m_word[i];
                m_full[i] = 0;
            end else if (ending) begin
                m_pos[i] = -1;
            end else if (m_pos[i] >= 0) begin
                m_pos[i]++;
            end
            if (acc) begin
                m_full[i] = 1;
                m_word[i] = s_data;
            end
            m_rdy[i] = 1;
        end
    endtask

    // {s_ready, busy, bck, le, d1, d0, underrun}
    function automatic logic [6:0] model_out(input int i);
        logic [6:0]  e;
        logic [1:0]  d;
        logic [31:0] w;
        int hdv, per, b, p;
        bit high;
        e    = '0;
        d    = '0;
        e[6] = m_rdy[i] && !m_full[i] && !reset;
        e[0] = m_under[i];
        if (m_pos[i] >= 0) begin
            hdv  = hd_of(i);
            per  = m_pos[i] / (2 * hdv);
            high = ((m_pos[i] / hdv) % 2) == 1;
            p    = FB - m_n[i];
            e[5] = 1'b1;
            if (per < p) begin
                e[4] = m_cont[i] && high;
            end else begin
                b    = per - p;
                e[4] = high;
                e[3] = (b == m_n[i] - 1);
                for (int k = 0; k < 2; k++) begin
                    w    = m_fw[i][32*k +: 32];
                    d[k] = w[31 - b];
                    if (m_inv[i] && b == 0) d[k] = ~d[k];
                end
            end
            e[2:1] = d;
        end
        return e;
    endfunction

    function automatic logic [6:0] dut_out(input int i);
        logic [1:0] d;
        d = (i == 0) ? dout0 : dout1;
        return {s_ready_v[i], busy_v[i], bck_v[i], le_v[i], d, und_v[i]};
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check_val("cycle_dut0", dut_out(0), model_out(0));
                check_val("cycle_dut1", dut_out(1), model_out(1));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    typedef struct {
        int busy; int rises; int hi; int le; int und; int falls; int first_rise;
        logic [23:0] b1; logic [23:0] b0;
    } meas_t;

    meas_t ma, mb;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] w);
        bit r, done;
        done    = 0;
        s_data  = w;
        s_valid = 1'b1;
        for (int t = 0; t < 1000 && !done; t++) begin
            r = s_ready_v[0];
            tick();
            if (r) done = 1;
        end
        s_valid = 1'b0;
        if (!done) check_val("send_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 2000 && !(busy_v == 2'b00 && s_ready_v == 2'b11); t++) tick();
        check_val("idle", {busy_v, s_ready_v}, 4'b0011);
    endtask

    // Waveform statistics of one instance; serial bits are taken once per high phase,
    // skipping the first pre_highs high phases (preamble pulses).
    task automatic measure(input int inst, input int cycles, input int pre_highs, output meas_t m);
        logic b, pb, bu, pbusy;
        logic [1:0] d;
        int h;
        m = '{default: 0};
        m.first_rise = -1;
        pb = 0; pbusy = 0; h = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            b  = bck_v[inst];
            bu = busy_v[inst];
            d  = (inst == 0) ? dout0 : dout1;
            if (b && !pb) begin
                m.rises++;
                if (m.first_rise < 0) m.first_rise = m.busy;
                h++;
                if (h > pre_highs) begin
                    m.b1 = {m.b1[22:0], d[1]};
                    m.b0 = {m.b0[22:0], d[0]};
                end
            end
            if (!bu && pbusy) m.falls++;
            if (bu) m.busy++;
            if (b) m.hi++;
            if (le_v[inst]) m.le++;
            if (und_v[inst]) m.und++;
            pb = b;
            pbusy = bu;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        check_val("rst_outs", {bck_v, le_v, busy_v, und_v, dout0, dout1, s_ready_v}, 14'h0);
        #1 reset = 1'b0;
        check_val("rdy_before_edge", s_ready_v, 2'b00);
        tick();
        check_val("rdy_after_edge", s_ready_v, 2'b11);

        // NOS16, continuous bck
        nos_bitnum = NOS16; bck_cont = 1'b1;
        fork
            measure(0, 260, 16, ma);
            measure(1, 260, 16, mb);
            send({32'hA5A5_0000, 32'h1234_0000});
        join
        check_val("t1_busy", ma.busy, 64);
        check_val("t1_rises", ma.rises, 32);
        check_val("t1_le", ma.le, 2);
        check_val("t1_und", ma.und, 1);
        check_val("t1_ch1", ma.b1, 24'h00A5A5);
        check_val("t1_ch0", ma.b0, 24'h001234);
        check_val("t1_busy_hd3", mb.busy, 192);
        check_val("t1_ch1_hd3", mb.b1, 24'h00A5A5);
        wait_idle();

        // NOS24, bck held low in the preamble
        nos_bitnum = NOS24; bck_cont = 1'b0;
        fork
            measure(0, 260, 0, ma);
            send({32'hDEAD_BEEF, 32'h0000_0100});
        join
        check_val("t2_rises", ma.rises, 24);
        check_val("t2_first_rise", ma.first_rise, 17);
        check_val("t2_le", ma.le, 2);
        check_val("t2_ch1", ma.b1, 24'hDEADBE);
        check_val("t2_ch0", ma.b0, 24'h000001);
        wait_idle();

        // back-to-back frames
        nos_bitnum = NOS16; bck_cont = 1'b1;
        fork
            measure(0, 200, 16, ma);
            measure(1, 440, 16, mb);
            begin
                send({32'h0F0F_0000, 32'hF0F0_0000});
                send({32'h1357_0000, 32'h2468_0000});
            end
        join
        check_val("t3_busy", ma.busy, 128);
        check_val("t3_falls", ma.falls, 1);
        check_val("t3_und", ma.und, 1);
        check_val("t3_busy_hd3", mb.busy, 384);
        check_val("t3_und_hd3", mb.und, 1);
        wait_idle();

        // NOS18, divider of 3 on dut1
        nos_bitnum = NOS18; bck_cont = 1'b1;
        fork
            measure(0, 260, 14, ma);
            measure(1, 260, 14, mb);
            send({32'hFFFF_C000, 32'h0000_4000});
        join
        check_val("t4_busy_hd3", mb.busy, 192);
        check_val("t4_rises_hd3", mb.rises, 32);
        check_val("t4_hi_hd3", mb.hi, 96);
        check_val("t4_le_hd3", mb.le, 6);
        check_val("t4_ch1_hd3", mb.b1, 24'h03FFFF);
        check_val("t4_ch0_hd3", mb.b0, 24'h000001);
        check_val("t4_busy", ma.busy, 64);
        wait_idle();

        // reset in the middle of a frame
        nos_bitnum = NOS16;
        send({32'h1111_0000, 32'h2222_0000});
        repeat (20) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("rst_async", {bck_v, le_v, busy_v, und_v, dout0, dout1, s_ready_v}, 14'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_val("rst_rdy_release", s_ready_v, 2'b00);
        tick();
        check_val("rst_rdy_edge", s_ready_v, 2'b11);
        fork
            measure(0, 260, 16, ma);
            measure(1, 260, 16, mb);
            send({32'hC3C3_0000, 32'h3C3C_0000});
        join
        check_val("t5_busy", ma.busy, 64);
        check_val("t5_und", ma.und, 1);
        check_val("t5_ch1", ma.b1, 24'h00C3C3);
        check_val("t5_busy_hd3", mb.busy, 192);
        wait_idle();

`ifdef NOS_DAC_SER_OFFSET_BIN_EN
        offset_bin = 1'b1;
        fork
            measure(0, 100, 16, ma);
            send({32'h8000_0000, 32'h8000_0000});
        join
        check_val("t6_offset_on", ma.b1, 24'h000000);
        wait_idle();
        offset_bin = 1'b0;
        fork
            measure(0, 100, 16, ma);
            send({32'h8000_0000, 32'h8000_0000});
        join
        check_val("t6_offset_off", ma.b1, 24'h008000);
        wait_idle();
`endif

        // randomized traffic with config changes at arbitrary times
        for (int c = 0; c < 3000; c++) begin
            s_valid = ($urandom_range(3) == 0);
            s_data  = {$urandom, $urandom};
            if ($urandom_range(15) == 0) nos_bitnum = NOS_BITNUM'(2'($urandom_range(3)));
            if ($urandom_range(15) == 0) bck_cont = 1'($urandom_range(1));
`ifdef NOS_DAC_SER_OFFSET_BIN_EN
            if ($urandom_range(15) == 0) offset_bin = 1'($urandom_range(1));
`endif
            tick();
        end
        s_valid = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nos_dac_serializer.md
# nos_dac_serializer

Parametrised NOS (non-oversampling) DAC serializer. Converts N_CH-channel 32-bit PCM words into simultaneous-mode parallel-data DAC streams: one shared bit clock, one shared latch enable, one serial data line per channel. Sits between the I2S receiver/sample FIFO and the DAC pins inside the NOS DAC transceiver. It adds a one-deep input buffer with valid/ready handshake and a programmable bit-clock divider.

## Interface
- N_CH, 2: channel count; channel k occupies s_data[32k+31:32k] and drives data_out[k]. With N_CH=2, ch1 is left and ch0 is right.
- FRAME_BCKS, 32: bit-clock periods per frame; legal range 24..255.
- HALF_DIV, 1: clk cycles per bit-clock phase; legal range 1..256.

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_data  in  N_CH*32  sample words, MSB-aligned (I2S_BITS=32 per channel)
- s_valid  in  1  sample present
- s_ready  out  1  buffer can accept
- nos_bitnum  in  NOS_BITNUM  DAC word width: 16/18/20/24
- bck_cont  in  1  1 = bck toggles during the preamble; 0 = bck held low during the preamble
- bck  out  1  DAC bit clock
- le  out  1  DAC latch enable
- data_out  out  N_CH  serial data, MSB first
- busy  out  1  frame in progress
- underrun  out  1  one-cycle pulse when a frame ends with the buffer empty

## Operation
- The handshake completes on a clk edge with s_valid && s_ready. The accepted word goes into a one-entry buffer. s_ready = !buf_full, and s_ready is forced to 0 while reset is high.
- At frame load:
  - nos_bitnum (N), bck_cont and all channel words are captured. Config changes mid-frame have no effect.
  - Lane k loads s_word_k[31:32-N], zero-extended to 24 bits. The buffer is freed.
- Frame = FRAME_BCKS bit periods. Each period is a low phase (bck=0) followed by a high phase (bck=1), each HALF_DIV cycles long.
- The frame has three parts, in order:
  - Preamble: P = FRAME_BCKS−N periods. data_out=0, le=0. bck follows the phase only if bck_cont=1, otherwise bck=0. When P=0 this part is skipped.
  - Data: N−1 periods. data_out[k] = current lane MSB, held over both phases. Lanes shift left by 1 at the end of each high phase.
  - Last bit: 1 period. Data is the final bit (LSB) and le=1 in both phases.
- State machine:
  - IDLE → PRE_LO (or DAT_LO when P=0) on load.
  - PRE_LO↔PRE_HI for P periods, then DAT_LO↔DAT_HI for N−1 periods, then LE_LO → LE_HI.
  - LE_HI end → load and go to PRE_LO/DAT_LO if buf_full, else go to IDLE and pulse underrun.
- Counters:
  - Phase counter runs 0..HALF_DIV−1.
  - Period counter is 8-bit and counts down: P at preamble, N−1 at data. Exit when it reaches 0 at a high-phase end.
- In IDLE: bck=le=data_out=0, busy=0.

## Timing
- Reset (async, any time): state=IDLE, buffer empty, lanes 0. bck, le, data_out, busy and underrun are 0 immediately. s_ready goes to 1 on the first edge after release.
- Latency from IDLE: accept at edge T → load at edge T+1 → first low phase occupies cycles after T+1. busy rises after T+1.
- Back-to-back: if buf_full at the final LE_HI edge, the next frame's first phase follows with no gap. Frame length is exactly 2·FRAME_BCKS·HALF_DIV cycles.
- Acceptance during a frame is allowed. A new word is accepted on the same edge the buffer is freed by a load only if s_ready was high before that edge. No same-edge pass-through.
- underrun is asserted for the single cycle after the LE_HI→IDLE edge.

## Configuration
- Macro: NOS_DAC_SER_OFFSET_BIN_EN.
- Defined: adds input port offset_bin (1 bit), captured at load. When 1, bit N−1 of every lane is inverted (two's complement → offset binary).
- Undefined: the port is absent and data passes unchanged.

## Structure
- The common package already holds I2S_BITS and NOS_BITNUM (NOS16/18/20/24). Add to it:
  - function nos_bits(NOS_BITNUM) returning 16/18/20/24;
  - state enum type nos_ser_state_t.
- Sub-module nos_dac_ser_lane: per-channel 24-bit load/shift register with optional MSB inversion, instantiated N_CH times via generate. The FSM, counters and buffer stay in the top.

## Test plan
All scenarios use N_CH=2, FRAME_BCKS=32, HALF_DIV=1 unless stated.
- NOS16, bck_cont=1, ch1=0xA5A5_0000, ch0=0x1234_0000 → 16 preamble bck pulses with data 0. Then data_out[1]=1010010110100101 and data_out[0]=0001001000110100, MSB first. le high only for the 16th bit (2 cycles). Frame is 64 cycles; underrun pulses after.
- NOS24, bck_cont=0 → bck low for the first 16 cycles, then 24 pulses; le on the last.
- Two words presented continuously → second frame starts the cycle after the first LE_HI. No underrun between the frames; one underrun after the second.
- HALF_DIV=3, NOS18 → every bck phase lasts 3 cycles, frame is 192 cycles, preamble is 14 periods.
- Reset asserted at cycle 20 of a frame → all outputs 0 in that cycle. After release, s_ready=1 and the next sample produces a clean full frame.
- With NOS_DAC_SER_OFFSET_BIN_EN defined, offset_bin=1, NOS16, word 0x8000_0000 → all 16 data bits 0. With offset_bin=0, the first data bit is 1.
